// File: rtl/mac_tile_sequencer_if.sv
// Job request, per-tile command and status signals between the control side,
// the tile sequencer and the streamer/engine datapath.
interface mac_tile_sequencer_if #(
    parameter int unsigned ADDR_W = 32,
    parameter int unsigned LEN_W  = 16,
    parameter int unsigned CNT_W  = 8
);
    // Job request channel
    logic              job_valid_i;
    logic              job_ready_o;
    logic [ADDR_W-1:0] job_a_base_i;
    logic [ADDR_W-1:0] job_b_base_i;
    logic [ADDR_W-1:0] job_d_base_i;
    logic [ADDR_W-1:0] job_stride_i;
    logic [LEN_W-1:0]  job_len_i;
    logic [CNT_W-1:0]  job_ntiles_i;

    // Per-tile command / completion
    logic              tile_start_o;
    logic [ADDR_W-1:0] tile_a_addr_o;
    logic [ADDR_W-1:0] tile_b_addr_o;
    logic [ADDR_W-1:0] tile_d_addr_o;
    logic [LEN_W-1:0]  tile_len_o;
    logic [CNT_W-1:0]  tile_idx_o;
    logic              tile_done_i;

    // Status
    logic              busy_o;
    logic              evt_done_o;
    logic              err_o;

    // Requester / datapath side
    modport master (
        output job_valid_i, job_a_base_i, job_b_base_i, job_d_base_i,
               job_stride_i, job_len_i, job_ntiles_i, tile_done_i,
        input  job_ready_o, tile_start_o, tile_a_addr_o, tile_b_addr_o,
               tile_d_addr_o, tile_len_o, tile_idx_o, busy_o, evt_done_o, err_o
    );

    // Sequencer side
    modport slave (
        input  job_valid_i, job_a_base_i, job_b_base_i, job_d_base_i,
               job_stride_i, job_len_i, job_ntiles_i, tile_done_i,
        output job_ready_o, tile_start_o, tile_a_addr_o, tile_b_addr_o,
               tile_d_addr_o, tile_len_o, tile_idx_o, busy_o, evt_done_o, err_o
    );
endinterface

// File: rtl/mac_tile_sequencer.sv
// Job-level controller: splits one job into tiles, issues a start pulse with
// per-tile addresses, waits for tile completion and strides the addresses.
module mac_tile_sequencer #(
    parameter int unsigned ADDR_W = 32,
    parameter int unsigned LEN_W  = 16,
    parameter int unsigned CNT_W  = 8
) (
    input  logic                 clk_i,
    input  logic                 rst_i,
    input  logic                 clear_i,
    mac_tile_sequencer_if.slave  bus
);

    typedef enum logic [2:0] {
        S_IDLE    = 3'd0,
        S_ISSUE   = 3'd1,
        S_WAIT    = 3'd2,
        S_ADVANCE = 3'd3,
        S_DONE    = 3'd4
    } state_t;

    state_t            state;
    logic [ADDR_W-1:0] stride_q;
    logic [CNT_W-1:0]  ntiles_q;
    logic [ADDR_W-1:0] a_addr_q;
    logic [ADDR_W-1:0] b_addr_q;
    logic [ADDR_W-1:0] d_addr_q;
    logic [LEN_W-1:0]  len_q;
    logic [CNT_W-1:0]  idx_q;
    logic              tile_start_q;
    logic              busy_q;
    logic              evt_done_q;
    logic              err_q;

    logic              job_ready_c;
    logic              accept_c;
    logic              job_bad_c;
    logic              last_tile_c;

    // Handshake and decode helpers; ready drops in the reset/clear cycle itself
    always_comb begin
        job_ready_c = (state == S_IDLE) && !rst_i && !clear_i;
        accept_c    = bus.job_valid_i && job_ready_c;
        job_bad_c   = (bus.job_len_i == '0) || (bus.job_ntiles_i == '0);
        // ntiles_q >= 1 whenever this is used, so the subtraction cannot wrap
        last_tile_c = (idx_q == (ntiles_q - CNT_W'(1)));
    end

    // Sequencer FSM with all tile/status outputs registered
    always_ff @(posedge clk_i) begin
        if (rst_i || clear_i) begin
            state        <= S_IDLE;
            stride_q     <= '0;
            ntiles_q     <= '0;
            a_addr_q     <= '0;
            b_addr_q     <= '0;
            d_addr_q     <= '0;
            len_q        <= '0;
            idx_q        <= '0;
            tile_start_q <= 1'b0;
            busy_q       <= 1'b0;
            evt_done_q   <= 1'b0;
            err_q        <= 1'b0;
        end else begin
            tile_start_q <= 1'b0;
            evt_done_q   <= 1'b0;
            case (state)
                S_IDLE: begin
                    if (accept_c) begin
                        stride_q <= bus.job_stride_i;
                        ntiles_q <= bus.job_ntiles_i;
                        a_addr_q <= bus.job_a_base_i;
                        b_addr_q <= bus.job_b_base_i;
                        d_addr_q <= bus.job_d_base_i;
                        len_q    <= bus.job_len_i;
                        idx_q    <= '0;
                        busy_q   <= 1'b1;
                        if (job_bad_c) begin
                            err_q      <= 1'b1;
                            evt_done_q <= 1'b1;
                            state      <= S_DONE;
                        end else begin
                            err_q        <= 1'b0;
                            tile_start_q <= 1'b1;
                            state        <= S_ISSUE;
                        end
                    end
                end
                S_ISSUE: begin
                    // A done pulse here is deliberately dropped
                    state <= S_WAIT;
                end
                S_WAIT: begin
                    if (bus.tile_done_i) begin
                        if (last_tile_c) begin
                            evt_done_q <= 1'b1;
                            state      <= S_DONE;
                        end else begin
                            state <= S_ADVANCE;
                        end
                    end
                end
                S_ADVANCE: begin
                    // Address arithmetic wraps modulo 2^ADDR_W
                    a_addr_q     <= a_addr_q + stride_q;
                    b_addr_q     <= b_addr_q + stride_q;
                    d_addr_q     <= d_addr_q + stride_q;
                    idx_q        <= idx_q + CNT_W'(1);
                    tile_start_q <= 1'b1;
                    state        <= S_ISSUE;
                end
                S_DONE: begin
                    busy_q <= 1'b0;
                    state  <= S_IDLE;
                end
                default: begin
                    busy_q <= 1'b0;
                    state  <= S_IDLE;
                end
            endcase
        end
    end

    // Drive interface outputs from the registered state
    assign bus.job_ready_o   = job_ready_c;
    assign bus.tile_start_o  = tile_start_q;
    assign bus.tile_a_addr_o = a_addr_q;
    assign bus.tile_b_addr_o = b_addr_q;
    assign bus.tile_d_addr_o = d_addr_q;
    assign bus.tile_len_o    = len_q;
    assign bus.tile_idx_o    = idx_q;
    assign bus.busy_o        = busy_q;
    assign bus.evt_done_o    = evt_done_q;
    assign bus.err_o         = err_q;

endmodule
